// File: rtl/rs_encoder_n7k5_stream.sv
// Streaming systematic RS(7,5) encoder over GF(8) (x^3+x+1), generator x^2 + 3x + 2.
// Symbols arrive one per accept; the finished codeword is held in cwOut until consumed.
`timescale 1ns/1ps
module rs_encoder_n7k5_stream #(
  parameter int N = 7,
  parameter int K = 5,
  parameter int m = 3
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           clear,
  input  logic [m-1:0]   symIn,
  input  logic           symValid,
  output logic           symReady,
  output logic [N*m-1:0] cwOut,
  output logic           cwValid,
  input  logic           cwReady
);

  // state | meaning
  // IDLE  | symCnt == 0, no partial frame
  // FILL  | symCnt 1..4, partial frame in parity/staging registers
  // EMPTY | output register free (cwValid low)
  // FULL  | cwValid high, output register occupied; independent of IDLE/FILL
  typedef enum logic {IDLE, FILL}  fill_t;
  typedef enum logic {EMPTY, FULL} out_t;

  fill_t        fill_st;
  out_t         out_st;
  logic [2:0]   symCnt;
  logic [m-1:0] r1, r0;
  logic [m-1:0] stage [4];

  logic [m-1:0] fb, r1_nxt, r0_nxt;
  logic         last, accept, done;

  function automatic logic [m-1:0] gf_x2(input logic [m-1:0] a);
    return {a[1], a[0] ^ a[2], a[2]};
  endfunction

  function automatic logic [m-1:0] gf_x3(input logic [m-1:0] a);
    return a ^ gf_x2(a);
  endfunction

  assign fb     = symIn ^ r1;
  assign r1_nxt = r0 ^ gf_x3(fb);
  assign r0_nxt = gf_x2(fb);

  assign last     = (fill_st == FILL) && (symCnt == 3'(K - 1));
  assign cwValid  = (out_st == FULL);
  // Back-pressure only the completing symbol, and only while the held word is not being taken.
  assign symReady = !(last && cwValid && !cwReady);
  assign accept   = symValid && symReady;
  assign done     = accept && last && !clear;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fill_st <= IDLE;
      out_st  <= EMPTY;
      symCnt  <= '0;
      r1      <= '0;
      r0      <= '0;
      cwOut   <= '0;
      for (int i = 0; i < 4; i++) stage[i] <= '0;
    end else begin
      if (clear) begin
        fill_st <= IDLE;
        symCnt  <= '0;
        r1      <= '0;
        r0      <= '0;
        for (int i = 0; i < 4; i++) stage[i] <= '0;
      end else if (accept) begin
        if (last) begin
          fill_st <= IDLE;
          symCnt  <= '0;
          r1      <= '0;
          r0      <= '0;
        end else begin
          fill_st              <= FILL;
          symCnt               <= symCnt + 3'd1;
          r1                   <= r1_nxt;
          r0                   <= r0_nxt;
          stage[symCnt[1:0]]   <= symIn;
        end
      end

      // A completing frame wins over a simultaneous consume so no word is lost.
      if (done) begin
        cwOut  <= {r0_nxt, r1_nxt, symIn, stage[3], stage[2], stage[1], stage[0]};
        out_st <= FULL;
      end else if (cwReady) begin
        out_st <= EMPTY;
      end
    end
  end

endmodule

// File: doc/rs_encoder_n7k5_stream.md
RS_ENCODER_N7K5_STREAM -- requirements
Module: rs_encoder_n7k5_stream

Interface
REQ-001 Parameter N, default 7, codeword length in symbols; only 7 is supported.
REQ-002 Parameter K, default 5, data symbols per codeword; only 5 is supported.
REQ-003 Parameter m, default 3, symbol width in bits over GF(8) with primitive polynomial x^3+x+1 (alpha = 3'b010).
REQ-004 Port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 Port rstn, input, 1, asynchronous active-low reset.
REQ-006 Port clear, input, 1, synchronous abort of a partial frame.
REQ-007 Port symIn, input, m, data symbol; the first symbol of a frame is the x^6 coefficient.
REQ-008 Port symValid, input, 1, symIn is valid this cycle.
REQ-009 Port symReady, output, 1, block accepts symIn this cycle.
REQ-010 Port cwOut, output, N*m, codeword; cwOut[0 +: m] holds x^6 and cwOut[6*m +: m] holds x^0.
REQ-011 Port cwValid, output, 1, cwOut holds a complete codeword.
REQ-012 Port cwReady, input, 1, downstream consumes cwOut.

Function
REQ-013 A symbol SHALL be accepted when symValid and symReady are both high in the same cycle.
REQ-014 The block SHALL encode systematically with g(x) = x^2 + 3x + 2, whose roots are 1 and alpha, using GF(8) arithmetic.
REQ-015 The parity LFSR SHALL hold registers r1 and r0. On each accept:
  - f = symIn ^ r1
  - r1 <= r0 ^ (f*3)
  - r0 <= f*2
REQ-016 A 3-bit counter symCnt SHALL run 0..4 and increment on each accept.
REQ-017 On the accept with symCnt==4, the block SHALL:
  - wrap symCnt to 0;
  - clear r1 and r0 to 0;
  - load cwOut as {p0, p1, d4..d0}, where p1 and p0 are the post-update r1 and r0 values;
  - set cwValid on the next cycle.
REQ-018 cwOut layout SHALL be:
  - data symbols in slots [0..4], in arrival order;
  - p1 in slot 5;
  - p0 in slot 6.
REQ-019 Data symbols SHALL be captured into their cwOut slot staging register as they are accepted.
REQ-020 Latency from the 5th accept to cwValid high SHALL be 1 cycle.
REQ-021 cwValid SHALL stay high and cwOut SHALL stay stable until the cycle in which cwReady is high.
REQ-022 In a cycle with cwValid high and cwReady high, cwValid SHALL clear on the next edge, unless a new codeword completes in that same cycle; in that case cwValid stays high and cwOut takes the new word.
REQ-023 symReady SHALL be 0 only when symCnt==4, cwValid==1 and cwReady==0; otherwise symReady SHALL be 1.
REQ-024 symReady SHALL depend combinationally on cwReady.
REQ-025 clear SHALL reset symCnt, r1, r0 and the staging slots to 0 on the next edge.
REQ-026 clear SHALL leave cwValid and cwOut unaffected.
REQ-027 clear SHALL override a simultaneous accept; the accepted symbol is discarded.
REQ-028 The state machine SHALL have the states:
  - IDLE (symCnt==0, no partial frame);
  - FILL (symCnt 1..4);
  - FULL (cwValid asserted, output register occupied), which is independent of the fill state.
REQ-029 Symbol filling SHALL continue while FULL is held, up to the 5th symbol, which is back-pressured per REQ-023.
REQ-030 The codeword SHALL satisfy both decoder syndromes:
  - XOR of all 7 symbols = 0;
  - Horner evaluation at alpha, from slot 0 to slot 6, = 0.

Reset
REQ-031 While rstn is low, the block SHALL asynchronously force:
  - symCnt, r1, r0 and staging to 0;
  - cwOut to 0;
  - cwValid to 0.
REQ-032 symReady SHALL be 1 during and after reset.
REQ-033 Reset asserted mid-frame SHALL discard the partial frame and any pending codeword.
REQ-034 Reset deassertion SHALL be synchronised externally; the block requires no internal initialisation cycles.

Verification
REQ-035 Scenario 1: symbols 1,0,0,0,0 with cwReady=1 -> one cycle after the 5th accept, cwValid=1 and cwOut slots = 1,0,0,0,0,5,4.
REQ-036 Scenario 2: symbols 1,1,1,1,1 -> cwOut slots = 1,1,1,1,1,7,6.
REQ-037 Scenario 3: all-zero data -> all-zero codeword, cwValid for 1 cycle.
REQ-038 Scenario 4: hold cwReady=0 and stream a second frame -> symReady=0 at that frame's 5th symbol; the first codeword stays stable; raising cwReady accepts the 5th symbol and the second codeword appears one cycle later.
REQ-039 Scenario 5: clear after 3 symbols, then send frame 1,0,0,0,0 -> codeword 1,0,0,0,0,5,4; the 3 earlier symbols are not present.
REQ-040 Scenario 6: random data for 10^4 frames with random symValid/cwReady, each codeword fed to the RS(7,5) decoder model -> error=0 and decoded data equals input; a single-symbol error injected in a data slot is corrected.
